imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Byte-stream program loader that sits directly upstream of the single-cycle core's instruction memory.
- Receives a framed image over a valid/ready byte interface and assembles little-endian 32-bit words.
- Writes the words into instruction memory and holds the core in reset until the whole image is loaded and its checksum verifies.
- On success, releases the core so it fetches from BASE_ADDR.

Parameters:
- DEPTH, 64: instruction memory capacity in 32-bit words; the maximum loadable image length.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the word being written.
- imem_wdata  output  32  assembled word.
- core_rst  output  1  reset to the core; high = held in reset.
- done  output  1  image loaded and verified; core running.
- error  output  1  frame rejected (length or checksum).

Behaviour:
- Decided interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state = LEN; in_ready = 1; imem_we = 0; imem_addr = BASE_ADDR; imem_wdata = 0.
  - core_rst = 1; done = 0; error = 0.
  - Byte counter, word counter, length register and checksum accumulator all cleared.
- Handshake:
  - A byte transfers on a rising edge when in_valid && in_ready.
  - in_data is sampled only on a transfer.
  - in_ready is a registered function of state: 1 in LEN/DATA/CSUM, 0 in RUN/ERR.
  - in_valid with in_ready = 0 has no effect.
- Frame format: 4-byte word count N (little-endian), then N*4 payload bytes (each word little-endian), then 1 checksum byte.
  - Expected checksum = sum of payload bytes mod 256. Header bytes are excluded.
- FSM:
  - LEN: collect 4 bytes into N (byte i goes to bits [8i+7:8i]).
    - On the 4th byte: N == 0 -> CSUM; N > DEPTH -> ERR; else -> DATA.
  - DATA: shift each payload byte into the word buffer at lane byte_cnt[1:0], and add it to the checksum accumulator (8-bit, wraps).
    - On the 4th byte of a word, the next cycle has:
      - imem_we = 1 for exactly one cycle;
      - imem_addr = BASE_ADDR + 4*word_idx (32-bit, wraps);
      - imem_wdata = assembled word.
    - word_idx then increments. After word N-1 is accepted -> CSUM.
    - Back-to-back bytes at full rate are supported; imem_we for word k overlaps acceptance of word k+1's first byte.
  - CSUM: accept 1 byte. If it equals the accumulator -> RUN, else -> ERR.
  - RUN: core_rst = 0, done = 1, in_ready = 0. Held until rst.
  - ERR: error = 1, core_rst = 1, in_ready = 0. Held until rst.
- imem_addr and imem_wdata hold their last values when imem_we = 0.
- core_rst deasserts on the edge that enters RUN, which is registered. It never pulses low outside RUN.
- Reset mid-frame:
  - All partial words, counts and checksum are discarded; state returns to LEN.
  - Any imem_we pending for that cycle is cancelled.
  - core_rst is reasserted immediately (asynchronously).
- No write is issued for a word with fewer than 4 bytes received.
- Instruction memory contents from a rejected frame are not cleared; error and core_rst gate their use.
- Expected RTL size: 150–250 lines.

Test Plan:
- Nominal load: stream 02 00 00 00 | 93 00 50 00 | 13 01 A0 00 | CS = (93+00+50+00+13+01+A0+00) mod 256 = 0x97 -> imem_we pulses twice with (0x00, 0x00500093) then (0x04, 0x00A00113); then done = 1, core_rst = 0, in_ready = 0.
- Bad checksum: same frame with CS = 0x98 -> both writes occur; error = 1, core_rst stays 1, done = 0.
- Oversize length: header N = 65 with DEPTH = 64 -> ERR on the 4th header byte; no imem_we ever; in_ready = 0.
- Zero length: 00 00 00 00 then CS = 0x00 -> RUN with no writes; CS = 0x01 -> ERR.
- Back-pressure and gaps: randomly deassert in_valid between bytes of the nominal frame -> identical writes and addresses; bytes presented while in RUN are ignored.
- Reset mid-word: assert rst after 2 payload bytes of word 1 -> core_rst = 1 immediately, no write for the partial word; resending the full nominal frame loads correctly from address 0x00.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: length header, little-endian payload words, checksum.
// Writes instruction memory and holds the core in reset until the image verifies.
module imem_boot_loader #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [31:0] len_q, len_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        in_ready_q, core_rst_q, done_q, error_q;
    logic        xfer;
    logic [31:0] n_full;
    logic [31:0] word_full;

    assign xfer      = in_valid && in_ready_q;
    assign n_full    = {in_data, len_q[23:0]};
    assign word_full = {in_data, word_q[23:0]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        word_d     = word_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (xfer) begin
            unique case (state_q)
                S_LEN: begin
                    len_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (n_full == 32'd0)
                            state_d = S_CSUM;
                        else if (n_full > 32'(DEPTH))
                            state_d = S_ERR;
                        else
                            state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    csum_d     = csum_q + in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = BASE_ADDR + {word_idx_q[29:0], 2'b00};
                        wdata_d    = word_full;
                        word_idx_d = word_idx_q + 32'd1;
                        if (word_idx_q == len_q - 32'd1)
                            state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    state_d = (in_data == csum_q) ? S_RUN : S_ERR;
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered off the next state so they change with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LEN;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 32'd0;
            len_q      <= 32'd0;
            word_q     <= 32'd0;
            csum_q     <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            in_ready_q <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= (state_d == S_LEN) || (state_d == S_DATA) ||
                          (state_d == S_CSUM);
            core_rst_q <= (state_d != S_RUN);
            done_q     <= (state_d == S_RUN);
            error_q    <= (state_d == S_ERR);
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: nominal, bad checksum, oversize,
// zero length, gapped stream and mid-word reset.
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  frame[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_boot_loader #(
        .DEPTH(64),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .done(done),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wa.delete();
        wd.delete();
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame[i]) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'hEE;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = frame[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_nominal(input logic [7:0] cs);
        frame = '{8'h02, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h50, 8'h00,
                  8'h13, 8'h01, 8'hA0, 8'h00, cs};
    endtask

    task automatic check_nominal_writes(input string tag);
        check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, wa[0], 32'h0000_0000);
            check({tag, "_d0"}, wd[0], 32'h0050_0093);
            check({tag, "_a1"}, wa[1], 32'h0000_0004);
            check({tag, "_d1"}, wd[1], 32'h00A0_0113);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        do_reset();

        // nominal, checksum 0x97
        load_nominal(8'h97);
        send_frame(1'b0);
        check_nominal_writes("nom");
        check("nom_done", {31'd0, done}, 32'd1);
        check("nom_core_rst", {31'd0, core_rst}, 32'd0);
        check("nom_in_ready", {31'd0, in_ready}, 32'd0);
        check("nom_error", {31'd0, error}, 32'd0);
        check("nom_hold_addr", imem_addr, 32'h0000_0004);
        check("nom_hold_data", imem_wdata, 32'h00A0_0113);
        // bytes presented in RUN are ignored
        frame = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(1'b0);
        check("run_ign_nwr", 32'(wa.size()), 32'd2);
        check("run_ign_done", {31'd0, done}, 32'd1);

        // bad checksum
        do_reset();
        load_nominal(8'h98);
        send_frame(1'b0);
        check_nominal_writes("bcs");
        check("bcs_error", {31'd0, error}, 32'd1);
        check("bcs_core_rst", {31'd0, core_rst}, 32'd1);
        check("bcs_done", {31'd0, done}, 32'd0);
        check("bcs_in_ready", {31'd0, in_ready}, 32'd0);

        // oversize length 65
        do_reset();
        frame = '{8'h41, 8'h00, 8'h00, 8'h00,
                  8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(1'b0);
        check("big_nwr", 32'(wa.size()), 32'd0);
        check("big_error", {31'd0, error}, 32'd1);
        check("big_in_ready", {31'd0, in_ready}, 32'd0);
        check("big_core_rst", {31'd0, core_rst}, 32'd1);

        // length exactly DEPTH is accepted into DATA
        do_reset();
        frame = '{8'h40, 8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        check("max_error", {31'd0, error}, 32'd0);
        check("max_in_ready", {31'd0, in_ready}, 32'd1);

        // zero length, good and bad checksum
        do_reset();
        frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        check("z0_nwr", 32'(wa.size()), 32'd0);
        check("z0_done", {31'd0, done}, 32'd1);
        check("z0_core_rst", {31'd0, core_rst}, 32'd0);
        do_reset();
        frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        send_frame(1'b0);
        check("z1_error", {31'd0, error}, 32'd1);
        check("z1_done", {31'd0, done}, 32'd0);

        // gapped stream
        do_reset();
        load_nominal(8'h97);
        send_frame(1'b1);
        check_nominal_writes("gap");
        check("gap_done", {31'd0, done}, 32'd1);

        // reset after two payload bytes of word 1
        do_reset();
        frame = '{8'h02, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h50, 8'h00,
                  8'h13, 8'h01};
        send_frame(1'b0);
        check("mid_nwr_pre", 32'(wa.size()), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_core_rst", {31'd0, core_rst}, 32'd1);
        check("mid_addr", imem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_nwr_post", 32'(wa.size()), 32'd1);
        wa.delete();
        wd.delete();
        load_nominal(8'h97);
        send_frame(1'b0);
        check_nominal_writes("rel");
        check("rel_done", {31'd0, done}, 32'd1);
        check("rel_core_rst", {31'd0, core_rst}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
